// File: rtl/video_pll_lock_sequencer_pkg.sv
// Shared types and constants for the video PLL lock sequencer.
// State encodings are visible on seq_state, so they are fixed here.
package video_pll_lock_sequencer_pkg;

    localparam int SEQ_STATE_W = 3;
    localparam int LOSS_CNT_W  = 8;

    typedef enum logic [SEQ_STATE_W-1:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABILIZE = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } seq_state_t;

    // Saturating increment for the lock-loss counter.
    function automatic logic [LOSS_CNT_W-1:0] sat_inc(
        input logic [LOSS_CNT_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/video_pll_lock_sequencer_sync2.sv
// Two-flop synchroniser for a single asynchronous level.
// Both flops clear on the asynchronous active-low reset.
module video_pll_lock_sequencer_sync2 (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the asynchronous input through two flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/video_pll_lock_sequencer.sv
// Video PLL power-up / recovery sequencer: pulses the PLL reset, waits for
// a stable lock, releases the video reset and retries or faults on timeout.
module video_pll_lock_sequencer
    import video_pll_lock_sequencer_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int MAX_RETRIES         = 4,
    parameter int CNT_W               = 20
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   pll_locked,
    input  logic                   sw_restart,
    input  logic                   status_clear,
    output logic                   pll_rst,
    output logic                   video_reset_n,
    output logic [SEQ_STATE_W-1:0] seq_state,
    output logic [LOSS_CNT_W-1:0]  lock_loss_count,
    output logic                   timeout_sticky,
    output logic                   fault
);

    localparam logic [CNT_W-1:0] RST_LAST =
        CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST =
        CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST =
        CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [7:0] RETRY_LIMIT = 8'(MAX_RETRIES);

    seq_state_t       state;
    logic [CNT_W-1:0] timer;
    logic [7:0]       retries;
    logic [7:0]       retries_inc;
    logic             locked_s;

    assign retries_inc = retries + 8'd1;
    assign seq_state   = state;

    video_pll_lock_sequencer_sync2 u_lock_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (pll_locked),
        .q       (locked_s)
    );

    // Sequencer FSM with its timer, retry count and status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= ST_RESET_PLL;
            timer           <= '0;
            retries         <= '0;
            pll_rst         <= 1'b1;
            video_reset_n   <= 1'b0;
            fault           <= 1'b0;
            lock_loss_count <= '0;
            timeout_sticky  <= 1'b0;
        end else begin
            if (sw_restart) begin
                state         <= ST_RESET_PLL;
                timer         <= '0;
                retries       <= '0;
                pll_rst       <= 1'b1;
                video_reset_n <= 1'b0;
                fault         <= 1'b0;
            end else begin
                unique case (state)
                    ST_RESET_PLL: begin
                        pll_rst       <= 1'b1;
                        video_reset_n <= 1'b0;
                        fault         <= 1'b0;
                        if (timer == RST_LAST) begin
                            state   <= ST_WAIT_LOCK;
                            timer   <= '0;
                            pll_rst <= 1'b0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    ST_WAIT_LOCK: begin
                        if (locked_s) begin
                            state <= ST_STABILIZE;
                            timer <= '0;
                        end else if (timer == TIMEOUT_LAST) begin
                            timeout_sticky <= 1'b1;
                            retries        <= retries_inc;
                            timer          <= '0;
                            if (retries_inc == RETRY_LIMIT) begin
                                state <= ST_FAULT;
                                fault <= 1'b1;
                            end else begin
                                state   <= ST_RESET_PLL;
                                pll_rst <= 1'b1;
                            end
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    ST_STABILIZE: begin
                        if (!locked_s) begin
                            state <= ST_WAIT_LOCK;
                            timer <= '0;
                        end else if (timer == STABLE_LAST) begin
                            state         <= ST_RUN;
                            timer         <= '0;
                            retries       <= '0;
                            video_reset_n <= 1'b1;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (!locked_s) begin
                            state           <= ST_RESET_PLL;
                            timer           <= '0;
                            pll_rst         <= 1'b1;
                            video_reset_n   <= 1'b0;
                            lock_loss_count <= sat_inc(lock_loss_count);
                        end
                    end
                    ST_FAULT: begin
                        pll_rst       <= 1'b0;
                        video_reset_n <= 1'b0;
                        fault         <= 1'b1;
                    end
                    default: begin
                        state         <= ST_RESET_PLL;
                        timer         <= '0;
                        pll_rst       <= 1'b1;
                        video_reset_n <= 1'b0;
                        fault         <= 1'b0;
                    end
                endcase
            end
            if (status_clear) begin
                lock_loss_count <= '0;
                timeout_sticky  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_video_pll_lock_sequencer.sv
// Directed bench for the video PLL lock sequencer: a vector table for the
// main sequence plus hand-written lock-loss, saturation and reset checks.
module tb_video_pll_lock_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pll_locked;
    logic       sw_restart;
    logic       status_clear;
    logic       pll_rst;
    logic       video_reset_n;
    logic [2:0] seq_state;
    logic [7:0] lock_loss_count;
    logic       timeout_sticky;
    logic       fault;

    int n_vec  = 0;
    int n_miss = 0;
    int exp_loss;

    typedef struct {
        int         cyc;
        logic       lock;
        logic       sw;
        logic       clr;
        logic       rst;
        logic       vrn;
        logic [2:0] st;
        logic       flt;
        logic       stk;
        logic [7:0] loss;
    } vec_t;

    vec_t vecs[$];

    video_pll_lock_sequencer #(
        .RST_PULSE_CYCLES    (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (32),
        .MAX_RETRIES         (3),
        .CNT_W               (20)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .pll_locked      (pll_locked),
        .sw_restart      (sw_restart),
        .status_clear    (status_clear),
        .pll_rst         (pll_rst),
        .video_reset_n   (video_reset_n),
        .seq_state       (seq_state),
        .lock_loss_count (lock_loss_count),
        .timeout_sticky  (timeout_sticky),
        .fault           (fault)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(
        int c, logic lk, logic s, logic cl, logic r, logic v,
        logic [2:0] st, logic f, logic k, logic [7:0] l
    );
        vec_t t;
        t.cyc = c; t.lock = lk; t.sw = s; t.clr = cl;
        t.rst = r; t.vrn = v; t.st = st; t.flt = f;
        t.stk = k; t.loss = l;
        return t;
    endfunction

    task automatic check_all(
        input string name, input logic r, input logic v,
        input logic [2:0] st, input logic f, input logic k,
        input logic [7:0] l
    );
        n_vec++;
        if (pll_rst !== r || video_reset_n !== v || seq_state !== st ||
            fault !== f || timeout_sticky !== k ||
            lock_loss_count !== l) begin
            n_miss++;
            $display("FAIL %s: got rst=%0b vrn=%0b st=%0d fault=%0b sticky=%0b loss=%0d, want rst=%0b vrn=%0b st=%0d fault=%0b sticky=%0b loss=%0d",
                     name, pll_rst, video_reset_n, seq_state, fault,
                     timeout_sticky, lock_loss_count, r, v, st, f, k, l);
        end
    endtask

    task automatic chk(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget,
                              input string name);
        int n = 0;
        while (seq_state !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(seq_state), int'(s));
    endtask

    task automatic drop_lock(input string name);
        pll_locked = 1'b0;
        repeat (2) @(negedge clk);
        chk({name, " vrn_before"}, int'(video_reset_n), 1);
        @(negedge clk);
        exp_loss = (exp_loss < 255) ? exp_loss + 1 : 255;
        chk({name, " vrn_after"}, int'(video_reset_n), 0);
        chk({name, " loss"}, int'(lock_loss_count), exp_loss);
        pll_locked = 1'b1;
        wait_state(3'd3, 40, {name, " relock"});
    endtask

    initial begin
        reset_n      = 1'b0;
        pll_locked   = 1'b0;
        sw_restart   = 1'b0;
        status_clear = 1'b0;

        // cold start
        vecs.push_back(mk( 0,0,0,0, 1,0,3'd0,0,0,8'd0));
        vecs.push_back(mk( 3,0,0,0, 1,0,3'd0,0,0,8'd0));
        vecs.push_back(mk( 1,0,0,0, 0,0,3'd1,0,0,8'd0));
        vecs.push_back(mk( 9,0,0,0, 0,0,3'd1,0,0,8'd0));
        vecs.push_back(mk( 3,1,0,0, 0,0,3'd2,0,0,8'd0));
        vecs.push_back(mk( 7,1,0,0, 0,0,3'd2,0,0,8'd0));
        vecs.push_back(mk( 1,1,0,0, 0,1,3'd3,0,0,8'd0));
        vecs.push_back(mk( 5,1,0,0, 0,1,3'd3,0,0,8'd0));
        // lock loss in RUN
        vecs.push_back(mk( 2,0,0,0, 0,1,3'd3,0,0,8'd0));
        vecs.push_back(mk( 1,0,0,0, 1,0,3'd0,0,0,8'd1));
        // glitch during STABILIZE
        vecs.push_back(mk( 3,1,0,0, 1,0,3'd0,0,0,8'd1));
        vecs.push_back(mk( 1,1,0,0, 0,0,3'd1,0,0,8'd1));
        vecs.push_back(mk( 1,1,0,0, 0,0,3'd2,0,0,8'd1));
        vecs.push_back(mk( 3,1,0,0, 0,0,3'd2,0,0,8'd1));
        vecs.push_back(mk( 1,0,0,0, 0,0,3'd2,0,0,8'd1));
        vecs.push_back(mk( 2,1,0,0, 0,0,3'd1,0,0,8'd1));
        vecs.push_back(mk( 1,1,0,0, 0,0,3'd2,0,0,8'd1));
        vecs.push_back(mk( 7,1,0,0, 0,0,3'd2,0,0,8'd1));
        vecs.push_back(mk( 1,1,0,0, 0,1,3'd3,0,0,8'd1));
        // lock never returns: three timeouts then FAULT
        vecs.push_back(mk( 3,0,0,0, 1,0,3'd0,0,0,8'd2));
        vecs.push_back(mk( 4,0,0,0, 0,0,3'd1,0,0,8'd2));
        vecs.push_back(mk(31,0,0,0, 0,0,3'd1,0,0,8'd2));
        vecs.push_back(mk( 1,0,0,0, 1,0,3'd0,0,1,8'd2));
        vecs.push_back(mk( 4,0,0,0, 0,0,3'd1,0,1,8'd2));
        vecs.push_back(mk(32,0,0,0, 1,0,3'd0,0,1,8'd2));
        vecs.push_back(mk( 4,0,0,0, 0,0,3'd1,0,1,8'd2));
        vecs.push_back(mk(31,0,0,0, 0,0,3'd1,0,1,8'd2));
        vecs.push_back(mk( 1,0,0,0, 0,0,3'd4,1,1,8'd2));
        vecs.push_back(mk(20,0,0,0, 0,0,3'd4,1,1,8'd2));
        // software restart out of FAULT
        vecs.push_back(mk( 1,0,1,0, 1,0,3'd0,0,1,8'd2));
        vecs.push_back(mk( 4,1,0,0, 0,0,3'd1,0,1,8'd2));
        vecs.push_back(mk( 1,1,0,0, 0,0,3'd2,0,1,8'd2));
        vecs.push_back(mk( 7,1,0,0, 0,0,3'd2,0,1,8'd2));
        vecs.push_back(mk( 1,1,0,0, 0,1,3'd3,0,1,8'd2));
        // status clear
        vecs.push_back(mk( 1,1,0,1, 0,1,3'd3,0,0,8'd0));
        vecs.push_back(mk( 2,1,0,0, 0,1,3'd3,0,0,8'd0));

        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            pll_locked   = vecs[i].lock;
            sw_restart   = vecs[i].sw;
            status_clear = vecs[i].clr;
            repeat (vecs[i].cyc) @(negedge clk);
            check_all($sformatf("vec%0d", i), vecs[i].rst, vecs[i].vrn,
                      vecs[i].st, vecs[i].flt, vecs[i].stk, vecs[i].loss);
        end
        sw_restart   = 1'b0;
        status_clear = 1'b0;

        // repeated lock losses saturate the counter
        exp_loss = 0;
        for (int k = 0; k < 300; k++)
            drop_lock($sformatf("loss%0d", k));
        chk("loss_saturated", int'(lock_loss_count), 255);

        // clear on the same cycle as an increment
        pll_locked = 1'b0;
        repeat (2) @(negedge clk);
        status_clear = 1'b1;
        @(negedge clk);
        status_clear = 1'b0;
        chk("clear_vs_inc state", int'(seq_state), 0);
        chk("clear_vs_inc loss", int'(lock_loss_count), 0);
        exp_loss = 0;
        pll_locked = 1'b1;
        wait_state(3'd3, 40, "clear_relock");
        drop_lock("after_clear");

        // asynchronous reset during STABILIZE
        pll_locked = 1'b0;
        repeat (3) @(negedge clk);
        pll_locked = 1'b1;
        wait_state(3'd2, 40, "reach_stabilize");
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check_all("async_reset", 1, 0, 3'd0, 0, 0, 8'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check_all("restart_wait", 0, 0, 3'd1, 0, 0, 8'd0);
        @(negedge clk);
        check_all("restart_stab", 0, 0, 3'd2, 0, 0, 8'd0);
        repeat (7) @(negedge clk);
        check_all("restart_pre_run", 0, 0, 3'd2, 0, 0, 8'd0);
        @(negedge clk);
        check_all("restart_run", 0, 1, 3'd3, 0, 0, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_miss);
        $finish;
    end

endmodule
